// File: rtl/id_fwd_stage.sv
// Decode stage for the MIPS32 logic/shift/LUI/no-op subset with operand forwarding,
// load-use stall detection and the ID/EX pipeline register feeding EX.
module id_fwd_stage #(
  parameter int DATA_W  = 32,
  parameter int REG_AW  = 5,
  parameter int NUM_FWD = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [31:0]                 pc_i,
  input  logic [31:0]                 inst_i,
  input  logic                        inst_valid_i,
  input  logic                        stall_i,
  input  logic                        flush_i,
  output logic                        reg1_read_o,
  output logic                        reg2_read_o,
  output logic [REG_AW-1:0]           reg1_addr_o,
  output logic [REG_AW-1:0]           reg2_addr_o,
  input  logic [DATA_W-1:0]           reg1_data_i,
  input  logic [DATA_W-1:0]           reg2_data_i,
  input  logic [NUM_FWD-1:0]          fwd_wreg_i,
  input  logic [NUM_FWD*REG_AW-1:0]   fwd_wd_i,
  input  logic [NUM_FWD*DATA_W-1:0]   fwd_wdata_i,
  input  logic                        ex_is_load_i,
  output logic                        stallreq_o,
  output logic [7:0]                  ex_aluop_o,
  output logic [2:0]                  ex_alusel_o,
  output logic [DATA_W-1:0]           ex_reg1_o,
  output logic [DATA_W-1:0]           ex_reg2_o,
  output logic [REG_AW-1:0]           ex_wd_o,
  output logic                        ex_wreg_o,
  output logic [31:0]                 ex_pc_o,
  output logic                        ex_inst_invalid_o
);

  localparam logic [7:0] EXE_NOP_OP    = 8'b0000_0000;
  localparam logic [7:0] EXE_AND_OP    = 8'b0010_0100;
  localparam logic [7:0] EXE_OR_OP     = 8'b0010_0101;
  localparam logic [7:0] EXE_XOR_OP    = 8'b0010_0110;
  localparam logic [7:0] EXE_NOR_OP    = 8'b0010_0111;
  localparam logic [7:0] EXE_SLL_OP    = 8'b0111_1100;
  localparam logic [7:0] EXE_SRL_OP    = 8'b0000_0010;
  localparam logic [7:0] EXE_SRA_OP    = 8'b0000_0011;
  localparam logic [2:0] EXE_RES_NOP   = 3'b000;
  localparam logic [2:0] EXE_RES_LOGIC = 3'b001;
  localparam logic [2:0] EXE_RES_SHIFT = 3'b010;

  logic [5:0]        op_s;
  logic [4:0]        rs_s;
  logic [4:0]        rt_s;
  logic [4:0]        rd_s;
  logic [4:0]        sa_s;
  logic [5:0]        funct_s;
  logic [7:0]        aluop_s;
  logic [2:0]        alusel_s;
  logic              rd1_s;
  logic              rd2_s;
  logic [REG_AW-1:0] wd_s;
  logic              wreg_s;
  logic [DATA_W-1:0] imm_s;
  logic              invalid_s;
  logic [DATA_W-1:0] op1_s;
  logic [DATA_W-1:0] op2_s;
  logic [REG_AW-1:0] ex_wd0_s;
  logic              load_bubble_s;

  assign op_s    = inst_i[31:26];
  assign rs_s    = inst_i[25:21];
  assign rt_s    = inst_i[20:16];
  assign rd_s    = inst_i[15:11];
  assign sa_s    = inst_i[10:6];
  assign funct_s = inst_i[5:0];

  // Lowest forwarding slot wins; address 0 reads as zero; an unread port takes the immediate.
  function automatic logic [DATA_W-1:0] pick_operand(
    input logic                      rd_en,
    input logic [REG_AW-1:0]         addr,
    input logic [DATA_W-1:0]         imm,
    input logic [DATA_W-1:0]         rf_data,
    input logic [NUM_FWD-1:0]        wreg,
    input logic [NUM_FWD*REG_AW-1:0] wd,
    input logic [NUM_FWD*DATA_W-1:0] wdata
  );
    logic [DATA_W-1:0] v;
    v = rf_data;
    for (int k = NUM_FWD - 1; k >= 0; k--) begin
      v = (wreg[k] && (wd[k*REG_AW +: REG_AW] == addr)) ? wdata[k*DATA_W +: DATA_W] : v;
    end
    v = (addr == '0) ? '0 : v;
    return rd_en ? v : imm;
  endfunction

  // Instruction decode
  always_comb begin
    aluop_s   = EXE_NOP_OP;
    alusel_s  = EXE_RES_NOP;
    rd1_s     = 1'b0;
    rd2_s     = 1'b0;
    wd_s      = '0;
    wreg_s    = 1'b0;
    imm_s     = '0;
    invalid_s = 1'b0;
    if (inst_valid_i) begin
      case (op_s)
        6'h00: begin
          case (funct_s)
            6'h24, 6'h25, 6'h26, 6'h27, 6'h04, 6'h06, 6'h07: begin
              if (sa_s == 5'd0) begin
                rd1_s    = 1'b1;
                rd2_s    = 1'b1;
                wreg_s   = 1'b1;
                wd_s     = REG_AW'(rd_s);
                alusel_s = funct_s[5] ? EXE_RES_LOGIC : EXE_RES_SHIFT;
                case (funct_s)
                  6'h24:   aluop_s = EXE_AND_OP;
                  6'h25:   aluop_s = EXE_OR_OP;
                  6'h26:   aluop_s = EXE_XOR_OP;
                  6'h27:   aluop_s = EXE_NOR_OP;
                  6'h04:   aluop_s = EXE_SLL_OP;
                  6'h06:   aluop_s = EXE_SRL_OP;
                  default: aluop_s = EXE_SRA_OP;
                endcase
              end else begin
                invalid_s = 1'b1;
              end
            end
            6'h0F: begin
              invalid_s = 1'b0;
            end
            6'h00, 6'h02, 6'h03: begin
              if (rs_s == 5'd0) begin
                rd2_s    = 1'b1;
                wreg_s   = 1'b1;
                wd_s     = REG_AW'(rd_s);
                imm_s    = DATA_W'(sa_s);
                alusel_s = EXE_RES_SHIFT;
                case (funct_s)
                  6'h00:   aluop_s = EXE_SLL_OP;
                  6'h02:   aluop_s = EXE_SRL_OP;
                  default: aluop_s = EXE_SRA_OP;
                endcase
              end else begin
                invalid_s = 1'b1;
              end
            end
            default: invalid_s = 1'b1;
          endcase
        end
        6'h0C, 6'h0D, 6'h0E: begin
          rd1_s    = 1'b1;
          wreg_s   = 1'b1;
          wd_s     = REG_AW'(rt_s);
          imm_s    = DATA_W'(inst_i[15:0]);
          alusel_s = EXE_RES_LOGIC;
          case (op_s)
            6'h0C:   aluop_s = EXE_AND_OP;
            6'h0D:   aluop_s = EXE_OR_OP;
            default: aluop_s = EXE_XOR_OP;
          endcase
        end
        6'h0F: begin
          // LUI is OR of $0 with the shifted immediate, so the rs field must be zero.
          if (rs_s == 5'd0) begin
            rd1_s    = 1'b1;
            wreg_s   = 1'b1;
            wd_s     = REG_AW'(rt_s);
            imm_s    = DATA_W'({inst_i[15:0], 16'h0000});
            alusel_s = EXE_RES_LOGIC;
            aluop_s  = EXE_OR_OP;
          end else begin
            invalid_s = 1'b1;
          end
        end
        6'h33: begin
          invalid_s = 1'b0;
        end
        default: invalid_s = 1'b1;
      endcase
    end else begin
      invalid_s = 1'b0;
    end
  end

  assign reg1_read_o = rd1_s;
  assign reg2_read_o = rd2_s;
  assign reg1_addr_o = REG_AW'(rs_s);
  assign reg2_addr_o = REG_AW'(rt_s);

  assign op1_s = pick_operand(rd1_s, REG_AW'(rs_s), imm_s, reg1_data_i, fwd_wreg_i, fwd_wd_i, fwd_wdata_i);
  assign op2_s = pick_operand(rd2_s, REG_AW'(rt_s), imm_s, reg2_data_i, fwd_wreg_i, fwd_wd_i, fwd_wdata_i);

  assign ex_wd0_s   = fwd_wd_i[REG_AW-1:0];
  assign stallreq_o = !rst && !flush_i && ex_is_load_i && fwd_wreg_i[0] && (ex_wd0_s != '0) &&
                      ((rd1_s && (REG_AW'(rs_s) == ex_wd0_s)) || (rd2_s && (REG_AW'(rt_s) == ex_wd0_s)));

  assign load_bubble_s = rst || flush_i || (!stall_i && (stallreq_o || !inst_valid_i));

  // ID/EX register: reset/flush, then hold on stall, then bubble or capture
  always_ff @(posedge clk) begin
    if (load_bubble_s) begin
      ex_aluop_o        <= EXE_NOP_OP;
      ex_alusel_o       <= EXE_RES_NOP;
      ex_reg1_o         <= '0;
      ex_reg2_o         <= '0;
      ex_wd_o           <= '0;
      ex_wreg_o         <= 1'b0;
      ex_pc_o           <= 32'h0000_0000;
      ex_inst_invalid_o <= 1'b0;
    end else if (!stall_i) begin
      ex_aluop_o        <= aluop_s;
      ex_alusel_o       <= alusel_s;
      ex_reg1_o         <= op1_s;
      ex_reg2_o         <= op2_s;
      ex_wd_o           <= wd_s;
      ex_wreg_o         <= wreg_s && (wd_s != '0);
      ex_pc_o           <= invalid_s ? 32'h0000_0000 : pc_i;
      ex_inst_invalid_o <= invalid_s;
    end
  end

endmodule

// File: doc/id_fwd_stage.md
# id_fwd_stage

Parametrised instruction-decode stage with an integrated ID/EX pipeline register. It decodes the logic, shift, LUI and no-op subset of the MIPS32 integer ISA and reads operands from the register file. It resolves RAW hazards by forwarding from `NUM_FWD` downstream stages, and raises a load-use stall request. It sits between the IF/ID register and the EX stage, and its registered outputs drive EX directly.

## Interface
- `DATA_W`, 32, operand/result width (≥ 32).
- `REG_AW`, 5, register address width.
- `NUM_FWD`, 2, number of forwarding sources; slot 0 = EX (youngest), slot 1 = MEM, …
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `pc_i`  in  32  PC of the instruction in ID.
- `inst_i`  in  32  instruction word.
- `inst_valid_i`  in  1  IF/ID holds a real instruction; when 0, the stage decodes a bubble.
- `stall_i`  in  1  pipeline-control hold of the ID/EX register.
- `flush_i`  in  1  replace the ID/EX contents with a bubble.
- `reg1_read_o`, `reg2_read_o`  out  1  register-file read enables.
- `reg1_addr_o`, `reg2_addr_o`  out  REG_AW  read addresses: `inst_i[25:21]` and `inst_i[20:16]`.
- `reg1_data_i`, `reg2_data_i`  in  DATA_W  register-file read data.
- `fwd_wreg_i`  in  NUM_FWD  per-slot write enable.
- `fwd_wd_i`  in  NUM_FWD*REG_AW  per-slot destination address, packed with slot 0 in the LSBs.
- `fwd_wdata_i`  in  NUM_FWD*DATA_W  per-slot result, packed with slot 0 in the LSBs.
- `ex_is_load_i`  in  1  the instruction in slot 0 is a load; its data is not yet valid.
- `stallreq_o`  out  1  combinational load-use stall request to pipeline control.
- `ex_aluop_o`  out  8  registered ALU op, using the shared `EXE_*_OP` codes.
- `ex_alusel_o`  out  3  registered result select, using `EXE_RES_*`.
- `ex_reg1_o`, `ex_reg2_o`  out  DATA_W  registered operands.
- `ex_wd_o`  out  REG_AW  registered destination register.
- `ex_wreg_o`  out  1  registered write enable.
- `ex_pc_o`  out  32  registered PC.
- `ex_inst_invalid_o`  out  1  registered reserved-instruction flag.

## Operation
- **Decode (combinational)**
  - R-type, op=0, with shamt=0 required:
    - funct 0x25/0x24/0x26/0x27 decode to OR/AND/XOR/NOR with `EXE_RES_LOGIC`.
    - funct 0x04/0x06/0x07 decode to SLLV/SRLV/SRAV with `EXE_RES_SHIFT`.
    - All of these read rs and rt and write rd.
  - funct 0x0F is SYNC: decoded as a NOP, no reads, no write.
  - funct 0x00/0x02/0x03 with rs=0 decode to SLL/SRL/SRA:
    - reg1 is not read; operand 1 = zero-extended shamt.
    - reg2 = rt; destination = rd.
  - I-type:
    - ORI 0x0D, ANDI 0x0C, XORI 0x0E read rs with a zero-extended imm16 and write rt.
    - LUI 0x0F produces OR of $0 with `{imm16,16'h0}` and writes rt.
    - PREF 0x33 is a NOP.
  - Any other encoding, including R-type with a nonzero field where zero is required, is invalid:
    - outputs a bubble with `ex_inst_invalid_o`=1.
- **Operand selection, per operand**
  - If the port is not read, the operand is the immediate.
  - If the read address is 0, the operand is 0.
  - Otherwise, take the lowest slot k with `fwd_wreg_i[k]` set and `fwd_wd` equal to the read address, and use `fwd_wdata[k]`.
  - If no slot matches, use the register-file data.
- **Write enable:** `wreg` is forced to 0 when the destination is 0.
- **Load-use:** `stallreq_o` = `ex_is_load_i` & `fwd_wreg_i[0]` & `fwd_wd[0]`≠0 & (`fwd_wd[0]` matches an enabled, nonzero read address). It is held at 0 while `rst` or `flush_i` is asserted.
- **Bubble:** aluop=`EXE_NOP_OP`, alusel=`EXE_RES_NOP`, operands 0, wd 0, wreg 0, invalid 0, pc 0.
- **ID/EX register priority at each edge**
  1. `rst` loads a bubble.
  2. `flush_i` loads a bubble.
  3. `stall_i` holds the current contents.
  4. `stallreq_o` or `inst_valid_i`=0 loads a bubble.
  5. Otherwise the register loads the decoded instruction.

## Timing
- All `ex_*` outputs are 0 in the cycle after `rst`. `rst` asserted mid-operation wins over every other input at that edge.
- Latency is 1 cycle: an instruction present at edge N appears on `ex_*` after edge N.
- `stallreq_o` and the read ports are combinational in the same cycle. Pipeline control must hold IF/ID while `stallreq_o`=1.
- Forwarding is sampled at the capture edge only.

## Test plan
- **Reset:** assert `rst` for 2 cycles with an arbitrary `inst_i` -> all `ex_*` = 0 and `stallreq_o`=0.
- **ORI:** `inst_i`=0x34011100 (ori $1,$0,0x1100) -> next cycle `ex_aluop_o`=`EXE_OR_OP`, reg1=0, reg2=0x00001100, wd=1, wreg=1.
- **Forwarding priority:** 0x00221825 (or $3,$1,$2); slot0 writes $1=0xAAAA0000; slot1 writes $1=0x00005555; regfile $2=0x0F -> reg1=0xAAAA0000, reg2=0x0000000F, wd=3.
- **Load-use:** `ex_is_load_i`=1, slot0 wd=1, wreg=1, inst 0x00221825 -> `stallreq_o`=1 in the same cycle and a bubble on `ex_*` next cycle. Next cycle, with `ex_is_load_i`=0 and the same inst, the instruction decodes normally.
- **Stall/flush priority:** a loaded OR instruction with `stall_i`=1 for 3 cycles -> outputs unchanged. Then `stall_i`=1 with `flush_i`=1 -> bubble.
- **Invalid and $0 destination:** 0xFC000000 -> `ex_inst_invalid_o`=1, wreg=0. 0x34001234 (ori $0) -> wreg=0, wd=0.
